// File: rtl/fios_pkg.sv
// Shared FIOS definitions: default word geometry and the result-collector state type.
package fios_pkg;

  localparam int unsigned FIOS_S     = 16;
  localparam int unsigned FIOS_WIDTH = 17;

  // Width of a counter that must represent 0..words inclusive without wrapping.
  function automatic int unsigned count_width(input int unsigned words);
    return $clog2(words + 1);
  endfunction

  localparam int unsigned FIOS_CNT_W = count_width(FIOS_S);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } collector_state_t;

endpackage

// File: rtl/fios_result_collector.sv
// Assembles s result words (LSW first) from the last FIOS PE into one s*WIDTH product,
// delivers it on valid/ready, and raises sticky framing/overrun flags.
module fios_result_collector
  import fios_pkg::*;
#(
  parameter int unsigned s     = FIOS_S,
  parameter int unsigned WIDTH = FIOS_WIDTH
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               res_push_i,
  input  logic [WIDTH-1:0]   res_word_i,
  input  logic               done_i,
  output logic [s*WIDTH-1:0] result_o,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic               frame_err_o,
  output logic               overrun_o
);

  localparam int unsigned          CNT_W     = count_width(s);
  localparam logic [CNT_W-1:0]     LAST_SLOT = CNT_W'(s - 1);
  localparam logic [CNT_W-1:0]     FULL_CNT  = CNT_W'(s);

  collector_state_t   state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [s*WIDTH-1:0] result_q, result_d;
  logic               valid_q, valid_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;

  logic               handshake;
  logic               accept;
  logic               write_en;
  logic [CNT_W-1:0]   slot_idx;
  logic [s-1:0]       slot_we;

  assign handshake = valid_q & result_ready_i;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    count_d     = count_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    accept      = 1'b0;
    write_en    = 1'b0;
    slot_idx    = count_q;

    case (state_q)
      FULL: begin
        if (handshake) begin
          // The handshake frees the buffer this cycle, so a push here starts the next frame.
          state_d  = IDLE;
          count_d  = '0;
          slot_idx = '0;
          accept   = res_push_i;
        end else if (res_push_i) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        accept = res_push_i;
        if (!res_push_i && done_i) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
          count_d     = '0;
        end
      end
    endcase

    if (accept) begin
      write_en = 1'b1;
      if (slot_idx == LAST_SLOT) begin
        if (done_i) begin
          state_d = FULL;
          count_d = FULL_CNT;
        end else begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
          count_d     = '0;
        end
      end else if (done_i) begin
        frame_err_d = 1'b1;
        state_d     = IDLE;
        count_d     = '0;
      end else begin
        state_d = COLLECT;
        count_d = slot_idx + CNT_W'(1);
      end
    end

    valid_d = (state_d == FULL);
  end

  always_comb begin
    result_d = result_q;
    for (int k = 0; k < s; k++) begin
      slot_we[k] = write_en && (slot_idx == CNT_W'(k));
      if (slot_we[k]) result_d[k*WIDTH +: WIDTH] = res_word_i;
    end
  end

  // NOTE: the result register is reset too, because result_o must read zero out of reset.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      count_q     <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      count_q     <= count_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign frame_err_o    = frame_err_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_fios_result_collector.sv
// Self-checking bench for fios_result_collector (s=4, WIDTH=17): queue-based frame model,
// per-cycle compare, delivery scoreboard and directed literal expectations.
module tb_fios_result_collector;

  localparam int S = 4;
  localparam int W = 17;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         push = 1'b0;
  logic         done = 1'b0;
  logic         ready = 1'b0;
  logic [W-1:0] word = '0;
  logic [S*W-1:0] result;
  logic         valid, ferr, ovr;

  always #5 clk = ~clk;

  fios_result_collector #(.s(S), .WIDTH(W)) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .res_push_i     (push),
    .res_word_i     (word),
    .done_i         (done),
    .result_o       (result),
    .result_valid_o (valid),
    .result_ready_i (ready),
    .frame_err_o    (ferr),
    .overrun_o      (ovr)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [S*W-1:0] act, input logic [S*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame is the list of words since the last frame boundary.
  logic [W-1:0]   m_words[$];
  logic           m_pending;
  logic [S*W-1:0] m_result;
  logic           m_err, m_ovr;

  task automatic m_accept(input logic [W-1:0] w, input logic d);
    m_words.push_back(w);
    if (m_words.size() == S) begin
      if (d) begin
        for (int k = 0; k < S; k++) m_result[k*W +: W] = m_words[k];
        m_pending = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      m_words.delete();
    end else if (d) begin
      m_err = 1'b1;
      m_words.delete();
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_words.delete();
      m_pending = 1'b0;
      m_result  = '0;
      m_err     = 1'b0;
      m_ovr     = 1'b0;
    end else if (m_pending) begin
      if (ready) begin
        m_pending = 1'b0;
        if (push) m_accept(word, done);
      end else if (push) begin
        m_ovr = 1'b1;
      end
    end else if (push) begin
      m_accept(word, done);
    end else if (done) begin
      m_err = 1'b1;
      m_words.delete();
    end
  end

  bit             cmp_en = 1'b0;
  bit             sb_en = 1'b0;
  logic [S*W-1:0] exp_q[$];
  int             delivered = 0;

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("valid", S*W'(valid), S*W'(m_pending));
      check("frame_err", S*W'(ferr), S*W'(m_err));
      check("overrun", S*W'(ovr), S*W'(m_ovr));
      if (m_pending) check("result", result, m_result);
      if (sb_en && valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_underflow actual=delivery required=none at %0t", $time);
        end else begin
          check("scoreboard", result, exp_q.pop_front());
        end
        delivered++;
      end
    end
  end

  task automatic step(input logic p, input logic [W-1:0] w, input logic d, input logic r);
    push  = p;
    word  = w;
    done  = d;
    ready = r;
    @(posedge clk);
    #1;
    push = 1'b0;
    done = 1'b0;
  endtask

  task automatic frame(input logic [W-1:0] w0, w1, w2, w3);
    step(1'b1, w0, 1'b0, 1'b0);
    step(1'b1, w1, 1'b0, 1'b0);
    step(1'b1, w2, 1'b0, 1'b0);
    step(1'b1, w3, 1'b1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [S*W-1:0] e;
    logic [W-1:0]   fw[S];
    bit             r;
    bit             sent;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", S*W'(valid), '0);
    check("rst_result", result, '0);
    check("rst_flags", S*W'({ferr, ovr}), '0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Nominal frame
    step(1'b1, 17'h00001, 1'b0, 1'b0);
    step(1'b1, 17'h00002, 1'b0, 1'b0);
    step(1'b1, 17'h00003, 1'b0, 1'b0);
    check("nom_not_yet_valid", S*W'(valid), '0);
    step(1'b1, 17'h1FFFF, 1'b1, 1'b0);
    e = {17'h1FFFF, 17'h00003, 17'h00002, 17'h00001};
    check("nom_valid", S*W'(valid), S*W'(1));
    check("nom_result", result, e);
    check("model_pin", m_result, e);
    check("nom_flags", S*W'({ferr, ovr}), '0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("nom_valid_drop", S*W'(valid), '0);

    // Back-to-back: handshake in the same cycle as the next frame's first word
    frame(17'd5, 17'd6, 17'd7, 17'd8);
    check("b2b_first_valid", S*W'(valid), S*W'(1));
    step(1'b1, 17'h0AAAA, 1'b0, 1'b1);
    check("b2b_valid_drop", S*W'(valid), '0);
    step(1'b1, 17'h000B1, 1'b0, 1'b0);
    step(1'b1, 17'h000B2, 1'b0, 1'b0);
    step(1'b1, 17'h000B3, 1'b1, 1'b0);
    check("b2b_result", result, {17'h000B3, 17'h000B2, 17'h000B1, 17'h0AAAA});
    check("b2b_flags", S*W'({ferr, ovr}), '0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Backpressure and overrun
    frame(17'd10, 17'd20, 17'd30, 17'd40);
    e = {17'd40, 17'd30, 17'd20, 17'd10};
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      check("bp_hold", result, e);
    end
    step(1'b1, 17'h01234, 1'b0, 1'b0);
    check("bp_overrun", S*W'(ovr), S*W'(1));
    check("bp_still_valid", S*W'(valid), S*W'(1));
    check("bp_unchanged", result, e);
    step(1'b0, '0, 1'b0, 1'b1);
    check("bp_drop", S*W'(valid), '0);

    // Framing: early done, then missing done
    step(1'b1, 17'd1, 1'b0, 1'b0);
    step(1'b1, 17'd2, 1'b0, 1'b0);
    step(1'b1, 17'd3, 1'b1, 1'b0);
    check("early_done_err", S*W'(ferr), S*W'(1));
    check("early_done_novalid", S*W'(valid), '0);
    frame(17'h00011, 17'h00022, 17'h00033, 17'h00044);
    check("after_err_result", result, {17'h00044, 17'h00033, 17'h00022, 17'h00011});
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, W'(i + 100), 1'b0, 1'b0);
    check("no_done_novalid", S*W'(valid), '0);
    frame(17'h10001, 17'h10002, 17'h10003, 17'h10004);
    check("after_nodone_result", result, {17'h10004, 17'h10003, 17'h10002, 17'h10001});
    step(1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset mid-frame
    step(1'b1, 17'd7, 1'b0, 1'b0);
    step(1'b1, 17'd8, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_result", result, '0);
    check("async_rst_outs", S*W'({valid, ferr, ovr}), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    frame(17'h00F01, 17'h00F02, 17'h00F03, 17'h00F04);
    check("post_rst_result", result, {17'h00F04, 17'h00F03, 17'h00F02, 17'h00F01});
    step(1'b0, '0, 1'b0, 1'b1);

    // Random frames with ready stalls; never push while a result is stalled
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_en = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      for (int i = 0; i < S; i++) begin
        fw[i] = W'($urandom);
        e[i*W +: W] = fw[i];
      end
      exp_q.push_back(e);
      for (int i = 0; i < S; i++) begin
        sent = 1'b0;
        for (int t = 0; t < 64 && !sent; t++) begin
          r = ($urandom_range(0, 3) != 0);
          if ((m_pending && !r) || $urandom_range(0, 7) == 0) begin
            step(1'b0, '0, 1'b0, r);
          end else begin
            step(1'b1, fw[i], (i == S - 1), r);
            sent = 1'b1;
          end
        end
        if (!sent) begin
          checks++;
          failures++;
          $display("FAIL push_budget actual=unsent required=sent frame=%0d", f);
        end
      end
    end
    repeat (4) step(1'b0, '0, 1'b0, 1'b1);
    sb_en = 1'b0;
    check("rand_delivered", S*W'(delivered), S*W'(1000));
    check("rand_no_overrun", S*W'(ovr), '0);
    check("rand_no_frame_err", S*W'(ferr), '0);
    check("rand_sb_empty", S*W'(exp_q.size()), '0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
